alu_issue_stage: RTL and testbench

- Decode-to-execute issue stage for the RV32I core.
- Decodes the instruction into the ALU operation code, operand A, operand B and shift amount, and holds them in the ID/EX pipeline register.
- In the execute cycle it takes back the ALU flags (cf, zf, vf, sf) and resolves conditional branches into a registered one-cycle redirect.
- It drives the ALU inputs and consumes the ALU flag outputs.

---
 rtl/rv32_pkg.sv | 58 +++++
 rtl/rv32_imm_gen.sv | 24 ++
 rtl/alu_issue_stage.sv | 197 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the issue stage: ALU codes, opcodes,
// branch funct3 values and the immediate format selector.
package rv32_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_PASS_B = 4'b0011;
    localparam logic [3:0] ALU_OR     = 4'b0100;
    localparam logic [3:0] ALU_AND    = 4'b0101;
    localparam logic [3:0] ALU_XOR    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b1001;
    localparam logic [3:0] ALU_SRA    = 4'b1010;
    localparam logic [3:0] ALU_SLT    = 4'b1101;
    localparam logic [3:0] ALU_SLTU   = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // alt selects SUB/SRA in the funct3 slots that have an alternate op
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        logic [3:0] fn;
        case (f3)
            3'b000:  fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  fn = ALU_SLL;
            3'b010:  fn = ALU_SLT;
            3'b011:  fn = ALU_SLTU;
            3'b100:  fn = ALU_XOR;
            3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  fn = ALU_OR;
            default: fn = ALU_AND;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate extraction for the RV32I I/S/B/U/J formats.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_type_e   sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (sel)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes ALU operands into the ID/EX
// register and resolves conditional branches from the returned ALU flags.
module alu_issue_stage
    import rv32_pkg::*;
#(
    parameter int          XLEN            = 32,
    parameter logic [31:0] RESET_PC_TARGET = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [4:0]      ex_shamt,
    output logic [3:0]      ex_alufn,
    output logic            ex_illegal,
    input  logic            alu_cf,
    input  logic            alu_zf,
    input  logic            alu_vf,
    input  logic            alu_sf,
    output logic            br_redirect,
    output logic [XLEN-1:0] br_target
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    imm_type_e   imm_sel;
    logic [31:0] imm;

    logic        ill_d, br_d;
    logic [3:0]  fn_d;
    logic [31:0] a_d, b_d, tgt_d;
    logic [4:0]  shamt_d;

    logic        ex_valid_q, ill_q, br_q, redirect_q;
    logic [3:0]  fn_q;
    logic [31:0] a_q, b_q, tgt_q, br_target_q;
    logic [4:0]  shamt_q;
    logic [2:0]  f3_q;

    logic accept, cond, taken;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    rv32_imm_gen u_imm (
        .instr(instr),
        .sel  (imm_sel),
        .imm  (imm)
    );

    always_comb begin
        imm_sel = IMM_I;
        ill_d   = 1'b0;
        br_d    = 1'b0;
        fn_d    = ALU_ADD;
        a_d     = '0;
        b_d     = '0;
        unique case (1'b1)
            opc == OPC_OP: begin
                a_d = rs1_data;
                b_d = rs2_data;
                if (f7 == 7'b0000000)
                    fn_d = alu_fn(f3, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    fn_d = alu_fn(f3, 1'b1);
                else
                    ill_d = 1'b1;
            end
            opc == OPC_OPIMM: begin
                a_d = rs1_data;
                b_d = imm;
                if (f3 == 3'b001)
                    ill_d = (f7 != 7'b0);
                else if (f3 == 3'b101)
                    ill_d = ({f7[6], f7[4:0]} != 6'b0);
                fn_d = alu_fn(f3, f3 == 3'b101 && instr[30]);
            end
            opc == OPC_LUI: begin
                imm_sel = IMM_U;
                fn_d    = ALU_PASS_B;
                b_d     = imm;
            end
            opc == OPC_AUIPC: begin
                imm_sel = IMM_U;
                a_d     = pc;
                b_d     = imm;
            end
            opc == OPC_LOAD: begin
                a_d = rs1_data;
                b_d = imm;
            end
            opc == OPC_STORE: begin
                imm_sel = IMM_S;
                a_d     = rs1_data;
                b_d     = imm;
            end
            opc == OPC_JAL || opc == OPC_JALR: begin
                imm_sel = IMM_J;
                a_d     = pc;
                b_d     = 32'd4;
            end
            opc == OPC_BRANCH: begin
                imm_sel = IMM_B;
                fn_d    = ALU_SUB;
                a_d     = rs1_data;
                b_d     = rs2_data;
                br_d    = 1'b1;
                ill_d   = (f3 == 3'b010 || f3 == 3'b011);
            end
            default: ill_d = 1'b1;
        endcase
        // Unsupported encodings issue as a harmless zero ADD
        if (ill_d) begin
            fn_d = ALU_ADD;
            a_d  = '0;
            b_d  = '0;
            br_d = 1'b0;
        end
        shamt_d = ill_d ? 5'd0 : instr[24:20];
        tgt_d   = pc + imm;
    end

    always_comb begin
        cond = 1'b0;
        case (f3_q)
            F3_BEQ:  cond = alu_zf;
            F3_BNE:  cond = ~alu_zf;
            F3_BLT:  cond = alu_sf ^ alu_vf;
            F3_BGE:  cond = ~(alu_sf ^ alu_vf);
            F3_BLTU: cond = ~alu_cf;
            F3_BGEU: cond = alu_cf;
            default: cond = 1'b0;
        endcase
    end

    assign in_ready = ~ex_valid_q | ~ex_stall;
    assign accept   = in_valid & in_ready;
    assign taken    = ex_valid_q & br_q & ~ex_stall & ~flush & cond;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            shamt_q     <= '0;
            fn_q        <= ALU_ADD;
            ill_q       <= 1'b0;
            br_q        <= 1'b0;
            f3_q        <= '0;
            tgt_q       <= '0;
            redirect_q  <= 1'b0;
            br_target_q <= RESET_PC_TARGET;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= taken;
            if (taken)
                br_target_q <= tgt_q;
            if (!(ex_valid_q && ex_stall)) begin
                // A taken branch kills the wrong-path instruction
                ex_valid_q <= accept & ~taken;
                if (accept && !taken) begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    shamt_q <= shamt_d;
                    fn_q    <= fn_d;
                    ill_q   <= ill_d;
                    br_q    <= br_d;
                    f3_q    <= f3;
                    tgt_q   <= tgt_d;
                end
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_a        = a_q;
    assign ex_b        = b_q;
    assign ex_shamt    = shamt_q;
    assign ex_alufn    = fn_q;
    assign ex_illegal  = ill_q;
    assign br_redirect = redirect_q;
    assign br_target   = br_target_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus
// randomized traffic against a behavioural issue-stage model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic        ex_stall, flush;
    logic        ex_valid, ex_illegal;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_shamt;
    logic [3:0]  ex_alufn;
    logic        alu_cf, alu_zf, alu_vf, alu_sf;
    logic        br_redirect;
    logic [31:0] br_target;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .RESET_PC_TARGET(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .ex_stall   (ex_stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_shamt   (ex_shamt),
        .ex_alufn   (ex_alufn),
        .ex_illegal (ex_illegal),
        .alu_cf     (alu_cf),
        .alu_zf     (alu_zf),
        .alu_vf     (alu_vf),
        .alu_sf     (alu_sf),
        .br_redirect(br_redirect),
        .br_target  (br_target)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        ill;
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        br;
        logic [2:0]  f3;
        logic [31:0] tgt;
    } ref_t;

    // Model state: what the EX register and redirect should hold
    logic        m_init = 1'b0;
    logic        m_valid, m_redir;
    ref_t        m_ex;
    logic [31:0] m_btgt;

    function automatic ref_t ref_decode(input logic [31:0] ins,
        input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
        logic [3:0] tbl [8];
        ref_t r;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] ii, is, ib, iu;
        tbl = '{4'h0, 4'h9, 4'hD, 4'hF, 4'h7, 4'h8, 4'h4, 4'h5};
        f3 = ins[14:12];
        f7 = ins[31:25];
        ii = $signed(ins) >>> 20;
        is = (ii & ~32'h1F) | {27'b0, ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = ins & 32'hFFFFF000;
        r = '0;
        r.f3 = f3;
        r.tgt = p + ib;
        case (ins[6:0])
            7'h33: begin
                r.a = r1; r.b = r2; r.fn = tbl[f3];
                if (f7 == 7'h20 && f3 == 3'd0) r.fn = 4'h1;
                else if (f7 == 7'h20 && f3 == 3'd5) r.fn = 4'hA;
                else if (f7 != 7'h00) r.ill = 1'b1;
            end
            7'h13: begin
                r.a = r1; r.b = ii; r.fn = tbl[f3];
                if (f3 == 3'd1 && f7 != 0) r.ill = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) r.fn = 4'hA;
                    else if (f7 != 7'h00) r.ill = 1'b1;
                end
            end
            7'h37: begin r.fn = 4'h3; r.b = iu; end
            7'h17: begin r.a = p; r.b = iu; end
            7'h03: begin r.a = r1; r.b = ii; end
            7'h23: begin r.a = r1; r.b = is; end
            7'h6F, 7'h67: begin r.a = p; r.b = 32'd4; end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1'b1;
                else begin r.fn = 4'h1; r.a = r1; r.b = r2; r.br = 1'b1; end
            end
            default: r.ill = 1'b1;
        endcase
        if (r.ill) begin r.fn = 0; r.a = 0; r.b = 0; r.br = 0; end
        r.sh = r.ill ? 5'd0 : ins[24:20];
        return r;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_model();
        if (m_init) begin
            check("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
            check("in_ready", {31'b0, in_ready}, {31'b0, ~m_valid | ~ex_stall});
            check("ex_a", ex_a, m_ex.a);
            check("ex_b", ex_b, m_ex.b);
            check("ex_shamt", {27'b0, ex_shamt}, {27'b0, m_ex.sh});
            check("ex_alufn", {28'b0, ex_alufn}, {28'b0, m_ex.fn});
            check("ex_illegal", {31'b0, ex_illegal}, {31'b0, m_ex.ill});
            check("br_redirect", {31'b0, br_redirect}, {31'b0, m_redir});
            check("br_target", br_target, m_btgt);
        end
    endtask

    // Check current outputs, apply one cycle of inputs, advance the model
    task automatic step(input logic r, input logic iv, input logic [31:0] ins,
        input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
        input logic st, input logic fl);
        logic [31:0] d;
        logic tk;
        @(negedge clk);
        check_model();
        rst = r; in_valid = iv; instr = ins; pc = p;
        rs1_data = r1; rs2_data = r2; ex_stall = st; flush = fl;
        d = m_ex.a - m_ex.b;
        alu_zf = (d == 0);
        alu_sf = d[31];
        alu_cf = (m_ex.a >= m_ex.b);
        alu_vf = (m_ex.a[31] != m_ex.b[31]) && (d[31] != m_ex.a[31]);
        @(posedge clk);
        if (r) begin
            m_init = 1'b1;
            m_valid = 0; m_redir = 0; m_btgt = 0;
            m_ex = '0;
        end else if (fl) begin
            m_valid = 0; m_redir = 0;
        end else begin
            tk = m_valid && m_ex.br && !st && ref_taken(m_ex.f3, m_ex.a, m_ex.b);
            m_redir = tk;
            if (tk) m_btgt = m_ex.tgt;
            if (!(m_valid && st)) begin
                if (tk) m_valid = 0;
                else if (iv) begin m_valid = 1; m_ex = ref_decode(ins, p, r1, r2); end
                else m_valid = 0;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h01;
                    default: ;
                endcase
            end
            2: begin
                r[6:0] = 7'h13;
                case ($urandom_range(0, 2))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    default: ;
                endcase
            end
            3: r[6:0] = 7'h37;
            4: r[6:0] = 7'h17;
            5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;
            7: r[6:0] = $urandom_range(0, 1) ? 7'h6F : 7'h67;
            8: r[6:0] = 7'h63;
            default: ;
        endcase
        return r;
    endfunction

    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_SRAI = 32'h40355513;
    localparam logic [31:0] I_BLT  = 32'h00B54863;
    localparam logic [31:0] I_BGEU = 32'h00B57863;
    localparam logic [31:0] I_BEQ  = 32'h00B50863;
    localparam logic [31:0] I_MUL  = 32'h02B50533;

    initial begin
        rst = 1; in_valid = 0; instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
        ex_stall = 0; flush = 0;
        alu_cf = 0; alu_zf = 0; alu_vf = 0; alu_sf = 0;
        m_valid = 0; m_redir = 0; m_btgt = 0; m_ex = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_target", br_target, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);

        step(0, 1, I_ADD, 32'h40, 5, 7, 0, 0);
        #1;
        check("add_valid", {31'b0, ex_valid}, 32'd1);
        check("add_fn", {28'b0, ex_alufn}, 32'h0);
        check("add_a", ex_a, 32'd5);
        check("add_b", ex_b, 32'd7);

        step(0, 1, I_SRAI, 32'h44, 32'h80000000, 0, 0, 0);
        #1;
        check("srai_fn", {28'b0, ex_alufn}, 32'hA);
        check("srai_b40", {27'b0, ex_b[4:0]}, 32'd3);
        check("srai_shamt", {27'b0, ex_shamt}, 32'd3);

        step(0, 1, I_BLT, 32'h100, 32'hFFFFFFFF, 1, 0, 0);
        step(0, 1, I_ADD, 32'h104, 1, 2, 0, 0);
        #1;
        check("blt_redirect", {31'b0, br_redirect}, 32'd1);
        check("blt_target", br_target, 32'h110);
        check("blt_kill", {31'b0, ex_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("blt_pulse_end", {31'b0, br_redirect}, 32'd0);
        check("blt_target_hold", br_target, 32'h110);

        step(0, 1, I_BGEU, 32'h200, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("bgeu_nt", {31'b0, br_redirect}, 32'd0);

        step(0, 1, I_BEQ, 32'h300, 9, 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, I_ADD, 32'h304, 1, 1, 1, 0);
            #1;
            check("stall_redirect", {31'b0, br_redirect}, 32'd0);
            check("stall_fn", {28'b0, ex_alufn}, 32'h1);
            check("stall_a", ex_a, 32'd9);
            check("stall_valid", {31'b0, ex_valid}, 32'd1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("beq_after_stall", {31'b0, br_redirect}, 32'd1);
        check("beq_target", br_target, 32'h310);

        step(0, 1, I_ADD, 32'h400, 3, 4, 0, 0);
        step(0, 1, I_ADD, 32'h404, 3, 4, 1, 1);
        #1;
        check("flush_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_redirect", {31'b0, br_redirect}, 32'd0);

        step(0, 1, I_MUL, 32'h500, 5, 6, 0, 0);
        #1;
        check("mul_illegal", {31'b0, ex_illegal}, 32'd1);
        check("mul_fn", {28'b0, ex_alufn}, 32'h0);

        step(0, 1, I_ADD, 32'h504, 8, 9, 0, 0);
        step(1, 1, I_ADD, 32'h508, 8, 9, 0, 0);
        #1;
        check("rst_mid_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_mid_a", ex_a, 32'd0);
        check("rst_mid_target", br_target, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r1, r2;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 rand_instr(), $urandom, r1, r2,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
